// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter:
// FSM state enum, memory-select encodings, widths and default region bases.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned CNT_W  = 3;

    localparam logic [ADDR_W-1:0] DEF_CONST_BASE = 32'h0000_0200;
    localparam logic [ADDR_W-1:0] DEF_VAR_BASE   = 32'h0000_0800;
    // 128 words per region
    localparam logic [ADDR_W-1:0] REGION_BYTES   = 32'h0000_0200;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MISS   = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_CONST = 2'b01,
        SEL_VAR   = 2'b10
    } mem_sel_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU data port, debug read port, memory port.
// slave  : arbiter side
// master : environment side (CPU core, debug master, memories)
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_hit;
    logic              cpu_ready;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              io_req;
    logic [IDX_W-1:0]  io_addr;
    logic              io_valid;
    logic [DATA_W-1:0] io_rdata;

    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [IDX_W-1:0]  mem_index;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata_const;
    logic [DATA_W-1:0] mem_rdata_var;
    logic              err_addr;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_hit,
        output cpu_ready, cpu_stall, cpu_rdata,
        input  io_req, io_addr,
        output io_valid, io_rdata,
        output mem_we, mem_sel, mem_index, mem_wdata, err_addr,
        input  mem_rdata_const, mem_rdata_var
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_hit,
        input  cpu_ready, cpu_stall, cpu_rdata,
        output io_req, io_addr,
        input  io_valid, io_rdata,
        input  mem_we, mem_sel, mem_index, mem_wdata, err_addr,
        output mem_rdata_const, mem_rdata_var
    );

endinterface

// File: rtl/dmem_arbiter_miss_counter.sv
// Miss latency counter: load to 1, increment, terminal count at LIMIT.
// Ports: CLK, RESET (async active-low), load, inc, tc_c (count == LIMIT).
module miss_counter
    import dmem_pkg::*;
#(
    parameter int unsigned LIMIT = 5
) (
    input  logic CLK,
    input  logic RESET,
    input  logic load,
    input  logic inc,
    output logic tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU loads/stores with modelled miss latency, address
// decode into constant/variable regions, and a low-priority debug read port
// that uses the memory port in cycles without a completing CPU access.
// Ports: CLK, RESET (async active-low), bus (dmem_arbiter_if.slave).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned       MISS_LAT   = 5,
    parameter logic [ADDR_W-1:0] CONST_BASE = DEF_CONST_BASE,
    parameter logic [ADDR_W-1:0] VAR_BASE   = DEF_VAR_BASE
) (
    input  logic           CLK,
    input  logic           RESET,
    dmem_arbiter_if.slave  bus
);

    if (MISS_LAT < 1 || MISS_LAT > 7) begin : g_bad_lat
        $error("MISS_LAT must be in 1..7");
    end

    state_t           state, state_nx;
    logic             cnt_load, cnt_inc, cnt_tc;
    logic             cpu_use;
    logic             io_pend, io_serve;
    logic [IDX_W-1:0] io_idx, io_idx_eff;
    logic [ADDR_W-1:0] const_off, var_off;
    logic             in_const, in_var;

    miss_counter #(.LIMIT(MISS_LAT)) u_miss_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .tc_c  (cnt_tc)
    );

    // Region decode; offsets below one region size fall inside it, which also
    // discards the byte-offset bits.
    assign const_off = bus.cpu_addr - CONST_BASE;
    assign var_off   = bus.cpu_addr - VAR_BASE;
    assign in_const  = (const_off < REGION_BYTES);
    assign in_var    = (var_off < REGION_BYTES);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and CPU handshake
    always_comb begin
        state_nx      = state;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        cpu_use       = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.cpu_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_hit) begin
                        cpu_use       = 1'b1;
                        bus.cpu_ready = 1'b1;
                    end else begin
                        bus.cpu_stall = 1'b1;
                        cnt_load      = 1'b1;
                        state_nx      = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                bus.cpu_stall = 1'b1;
                cnt_inc       = 1'b1;
                if (cnt_tc) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An abandoned request still drains through here, but silently.
                cpu_use       = bus.cpu_req;
                bus.cpu_ready = bus.cpu_req;
                state_nx      = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Memory port mux: CPU access first, otherwise the debug read
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_sel   = SEL_NONE;
        bus.mem_index = '0;
        bus.cpu_rdata = '0;
        bus.err_addr  = 1'b0;
        io_serve      = 1'b0;
        io_idx_eff    = bus.io_req ? bus.io_addr : io_idx;
        if (cpu_use) begin
            bus.mem_index = bus.cpu_addr[IDX_W+1:2];
            if (in_const) begin
                bus.mem_sel = SEL_CONST;
            end else if (in_var) begin
                bus.mem_sel = SEL_VAR;
            end
            bus.mem_we   = bus.cpu_we & in_var;
            bus.err_addr = ~(in_const | in_var) | (bus.cpu_we & in_const);
            if (!bus.cpu_we) begin
                if (in_const) begin
                    bus.cpu_rdata = bus.mem_rdata_const;
                end else if (in_var) begin
                    bus.cpu_rdata = bus.mem_rdata_var;
                end
            end
        end else if (io_pend || bus.io_req) begin
            io_serve      = 1'b1;
            bus.mem_sel   = SEL_VAR;
            bus.mem_index = io_idx_eff;
        end
    end

    assign bus.mem_wdata = bus.cpu_wdata;

    // Debug read: pending request tracking and registered result
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            io_pend      <= 1'b0;
            io_idx       <= '0;
            bus.io_valid <= 1'b0;
            bus.io_rdata <= '0;
        end else begin
            io_pend      <= (io_pend | bus.io_req) & ~io_serve;
            bus.io_valid <= io_serve;
            if (bus.io_req) begin
                io_idx <= bus.io_addr;
            end
            if (io_serve) begin
                bus.io_rdata <= bus.mem_rdata_var;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory environment, cycle-level reference model
// with per-cycle compare, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned LAT = 5;

    logic CLK = 1'b0;
    logic RESET;
    logic mem_init;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .MISS_LAT   (LAT),
        .CONST_BASE (32'h200),
        .VAR_BASE   (32'h800)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Memory environment
    logic [31:0] const_mem [128];
    logic [31:0] var_mem   [128];

    assign bus.mem_rdata_const = const_mem[bus.mem_index];
    assign bus.mem_rdata_var   = var_mem[bus.mem_index];

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) var_mem[i] <= 32'h1000 + 32'(i);
        end else if (bus.mem_we) begin
            var_mem[bus.mem_index] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a miss counts down LAT waiting cycles after the request
    // cycle, then completes; the debug read takes any cycle the CPU leaves free.
    logic [31:0] var_shadow [128];
    int          m_wait = -1;
    bit          m_pend = 1'b0;
    logic [6:0]  m_pidx = '0;
    logic        exp_iov = 1'b0;
    logic [31:0] exp_iord = '0;

    always @(negedge CLK) begin : model
        logic        e_use, e_stall, e_serve, e_we, e_err, is_c, is_v;
        logic [1:0]  e_sel;
        logic [6:0]  e_idx, s_idx;
        logic [31:0] e_rd, a;
        int          w_next;

        if (!mem_init) begin
            for (int i = 0; i < 128; i++) var_shadow[i] = 32'h1000 + 32'(i);
        end
        if (!RESET) begin
            m_wait   = -1;
            m_pend   = 1'b0;
            m_pidx   = '0;
            exp_iov  = 1'b0;
            exp_iord = '0;
        end

        a    = bus.cpu_addr & ~32'h3;
        is_c = (a >= 32'h200) && (a <= 32'h3FC);
        is_v = (a >= 32'h800) && (a <= 32'h9FC);

        e_use = 1'b0; e_stall = 1'b0; w_next = m_wait;
        if (m_wait < 0) begin
            if (bus.cpu_req) begin
                if (bus.cpu_hit) e_use = 1'b1;
                else begin e_stall = 1'b1; w_next = LAT; end
            end
        end else if (m_wait > 0) begin
            e_stall = 1'b1;
            w_next  = m_wait - 1;
        end else begin
            e_use  = bus.cpu_req;
            w_next = -1;
        end

        e_serve = !e_use && (m_pend || bus.io_req);
        s_idx   = bus.io_req ? bus.io_addr : m_pidx;
        e_sel = 2'b00; e_idx = '0; e_we = 1'b0; e_err = 1'b0; e_rd = '0;
        if (e_use) begin
            e_sel = is_c ? 2'b01 : (is_v ? 2'b10 : 2'b00);
            e_idx = bus.cpu_addr[8:2];
            e_we  = bus.cpu_we && is_v;
            e_err = !(is_c || is_v) || (bus.cpu_we && is_c);
            if (!bus.cpu_we) e_rd = is_c ? const_mem[e_idx] : (is_v ? var_shadow[e_idx] : 32'h0);
        end else if (e_serve) begin
            e_sel = 2'b10;
            e_idx = s_idx;
        end

        chk("cpu_ready", 32'(bus.cpu_ready), 32'(e_use));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        chk("cpu_rdata", bus.cpu_rdata, e_rd);
        chk("mem_sel",   32'(bus.mem_sel), 32'(e_sel));
        chk("mem_index", 32'(bus.mem_index), 32'(e_idx));
        chk("mem_we",    32'(bus.mem_we), 32'(e_we));
        chk("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
        chk("err_addr",  32'(bus.err_addr), 32'(e_err));
        chk("io_valid",  32'(bus.io_valid), 32'(exp_iov));
        chk("io_rdata",  bus.io_rdata, exp_iord);

        if (RESET) begin
            m_wait  = w_next;
            exp_iov = e_serve;
            if (e_serve) exp_iord = var_shadow[s_idx];
            m_pend = (m_pend || bus.io_req) && !e_serve;
            if (bus.io_req) m_pidx = bus.io_addr;
            if (e_we) var_shadow[e_idx] = bus.cpu_wdata;
        end
    end

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hit,
                         input logic ioreq, input logic [6:0] ioaddr);
        @(posedge CLK);
        #1;
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_hit   = hit;
        bus.io_req    = ioreq;
        bus.io_addr   = ioaddr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 7'd0);
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        int stall_cnt;
        int pulses;
        bit done;

        RESET = 1'b0;
        mem_init = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_hit = 1'b0; bus.io_req = 1'b0; bus.io_addr = '0;
        for (int i = 0; i < 128; i++) const_mem[i] = 32'h800 + 32'(i) * 32'h20;

        repeat (3) @(posedge CLK);
        #1 mem_init = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b1;
        sample();
        chk("rst_ready", 32'(bus.cpu_ready), 32'h0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'h0);
        chk("rst_io_valid", 32'(bus.io_valid), 32'h0);
        chk("rst_io_rdata", bus.io_rdata, 32'h0);

        // Hit load from constant word 1
        drive(1'b1, 1'b0, 32'h204, 32'h0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("hit_ready", 32'(bus.cpu_ready), 32'h1);
        chk("hit_rdata", bus.cpu_rdata, 32'h820);
        chk("hit_sel", 32'(bus.mem_sel), 32'h1);

        // Miss store to variable word 2
        stall_cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive(1'b1, 1'b1, 32'h808, 32'hDEADBEEF, 1'b0, 1'b0, 7'd0);
            sample();
            if (bus.cpu_stall) stall_cnt++;
            if (bus.cpu_ready) begin
                done = 1'b1;
                chk("miss_we", 32'(bus.mem_we), 32'h1);
                chk("miss_idx", 32'(bus.mem_index), 32'h2);
                chk("miss_done_cycle", 32'(i), 32'd6);
            end
        end
        if (!done) chk("miss_timeout", 32'h0, 32'h1);
        chk("miss_stall_cycles", 32'(stall_cnt), 32'd6);
        idle();
        sample();
        chk("var2_written", var_mem[2], 32'hDEADBEEF);
        chk("model_var2", var_shadow[2], 32'hDEADBEEF);

        // Store to the constant region is refused but completes
        drive(1'b1, 1'b1, 32'h200, 32'h12345678, 1'b1, 1'b0, 7'd0);
        sample();
        chk("cstore_err", 32'(bus.err_addr), 32'h1);
        chk("cstore_we", 32'(bus.mem_we), 32'h0);
        chk("cstore_ready", 32'(bus.cpu_ready), 32'h1);
        idle();
        sample();
        chk("const0_kept", const_mem[0], 32'h800);

        // Debug read arriving during a hit waits one cycle
        drive(1'b1, 1'b0, 32'h208, 32'h0, 1'b1, 1'b1, 7'd2);
        sample();
        chk("io_hit_ready", 32'(bus.cpu_ready), 32'h1);
        idle();
        sample();
        chk("io_served_sel", 32'(bus.mem_sel), 32'h2);
        chk("io_served_idx", 32'(bus.mem_index), 32'h2);
        idle();
        sample();
        chk("io_valid_pulse", 32'(bus.io_valid), 32'h1);
        chk("io_rdata_val", bus.io_rdata, 32'hDEADBEEF);

        // Two pending debug reads: last index wins, a single pulse
        drive(1'b1, 1'b0, 32'h204, 32'h0, 1'b1, 1'b1, 7'd3);
        drive(1'b1, 1'b0, 32'h204, 32'h0, 1'b1, 1'b1, 7'd4);
        idle();
        sample();
        chk("io_last_wins_idx", 32'(bus.mem_index), 32'h4);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            idle();
            sample();
            if (bus.io_valid) pulses++;
        end
        chk("io_single_pulse", 32'(pulses), 32'h1);
        chk("io_last_wins_data", bus.io_rdata, 32'h1004);

        // Load from an unmapped address
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("unmapped_rdata", bus.cpu_rdata, 32'h0);
        chk("unmapped_err", 32'(bus.err_addr), 32'h1);
        chk("unmapped_sel", 32'(bus.mem_sel), 32'h0);

        // Request abandoned mid-miss; debug read served in a free cycle
        drive(1'b1, 1'b1, 32'h810, 32'hCAFEF00D, 1'b0, 1'b0, 7'd0);
        drive(1'b1, 1'b1, 32'h810, 32'hCAFEF00D, 1'b0, 1'b0, 7'd0);
        drive(1'b1, 1'b1, 32'h810, 32'hCAFEF00D, 1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 7'd5);
        sample();
        chk("io_same_cycle_sel", 32'(bus.mem_sel), 32'h2);
        chk("io_same_cycle_idx", 32'(bus.mem_index), 32'h5);
        repeat (8) idle();
        sample();
        chk("dropped_no_write", var_mem[4], 32'h1004);

        // Reset in the third miss cycle aborts the store
        drive(1'b1, 1'b1, 32'h814, 32'h55AA55AA, 1'b0, 1'b0, 7'd0);
        drive(1'b1, 1'b1, 32'h814, 32'h55AA55AA, 1'b0, 1'b0, 7'd0);
        drive(1'b1, 1'b1, 32'h814, 32'h55AA55AA, 1'b0, 1'b0, 7'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        sample();
        chk("rst_mid_stall", 32'(bus.cpu_stall), 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        sample();
        chk("post_rst_stall", 32'(bus.cpu_stall), 32'h0);
        chk("post_rst_io_valid", 32'(bus.io_valid), 32'h0);
        repeat (8) idle();
        sample();
        chk("rst_no_write", var_mem[5], 32'h1005);

        // Hit load from the variable region after everything
        drive(1'b1, 1'b0, 32'h808, 32'h0, 1'b1, 1'b0, 7'd0);
        sample();
        chk("final_var_load", bus.cpu_rdata, 32'hDEADBEEF);
        idle();
        sample();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
